// File: rtl/knn_topk_vote_if.sv
// rtl/knn_topk_vote_if.sv - sample/control bundle for the top-K neighbour voter
//
// Purpose : groups the start/sample handshake and the result outputs of
//           knn_topk_vote so the block can be connected with one port.
// Ports   : start, in_valid, in_distance, in_type, in_last (driver -> block)
//           in_ready, idle, inference_done, inferred_type (block -> driver)
// Modports: master = sample source / result sink, slave = knn_topk_vote.

interface knn_topk_vote_if #(
  parameter int DIST_W = 32,
  parameter int TYPE_W = 3
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_distance;
  logic [TYPE_W-1:0] in_type;
  logic              in_last;
  logic              idle;
  logic              inference_done;
  logic [TYPE_W-1:0] inferred_type;

  modport master (
    output start, in_valid, in_distance, in_type, in_last,
    input  in_ready, idle, inference_done, inferred_type
  );

  modport slave (
    input  start, in_valid, in_distance, in_type, in_last,
    output in_ready, idle, inference_done, inferred_type
  );
endinterface

// File: rtl/knn_topk_vote.sv
// rtl/knn_topk_vote.sv - top-K nearest neighbour list with per-class vote
//
// Purpose : keeps the K closest samples of a training set in a sorted list
//           (one insertion per cycle), then scans every class once and
//           reports the class with the highest score.
// Ports   : clk  - clock, all state on the rising edge
//           rst  - asynchronous active-high reset
//           bus  - knn_topk_vote_if.slave (start, sample stream, idle,
//                  inference_done pulse, inferred_type)
// Options : KNN_WEIGHTED_VOTE_EN - when defined, the entry at rank r adds
//           K-r to its class score; otherwise every valid entry adds 1.

module knn_topk_vote #(
  parameter int K      = 8,
  parameter int DIST_W = 32,
  parameter int TYPE_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  knn_topk_vote_if.slave  bus
);

  localparam int NCLS = 1 << TYPE_W;
`ifdef KNN_WEIGHTED_VOTE_EN
  localparam int MAX_SCORE = K * (K + 1) / 2;
`else
  localparam int MAX_SCORE = K;
`endif
  localparam int SCORE_W = $clog2(MAX_SCORE + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VOTE, S_DONE} state_t;

  state_t state, state_nx;

  logic [DIST_W-1:0]  ent_dist [K];
  logic [TYPE_W-1:0]  ent_type [K];
  logic [K-1:0]       ent_vld;

  logic [K-1:0]       lt;
  logic [K-1:0]       take_new;
  logic [K-1:0]       take_prev;
  logic               xfer;

  logic [TYPE_W-1:0]  cls;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;
  logic [TYPE_W-1:0]  best_type;
  logic [TYPE_W-1:0]  inferred_q;
  logic               last_cls;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign last_cls = (cls == TYPE_W'(NCLS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bus.start) state_nx = S_COLLECT;
      S_COLLECT: if (xfer && bus.in_last) state_nx = S_VOTE;
      S_VOTE:    if (last_cls) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready       = (state == S_COLLECT);
    bus.idle           = (state == S_IDLE);
    bus.inference_done = (state == S_DONE);
    bus.inferred_type  = inferred_q;
  end

  // Valid entries always form a sorted prefix, so lt[] is a thermometer:
  // zeros over entries the sample does not beat, ones from its slot onward.
  // The first set bit takes the new sample, every later set bit takes its
  // upper neighbour. An all-zero lt means the sample is discarded.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      lt[i] = !ent_vld[i] || (bus.in_distance < ent_dist[i]);
    end
    take_prev = lt & (lt << 1);
    take_new  = lt & ~(lt << 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld <= '0;
    end else if (state == S_IDLE && bus.start) begin
      ent_vld <= '0;
    end else if (xfer) begin
      if (take_new[0]) ent_vld[0] <= 1'b1;
      for (int i = 1; i < K; i++) begin
        if (take_new[i])       ent_vld[i] <= 1'b1;
        else if (take_prev[i]) ent_vld[i] <= ent_vld[i-1];
      end
    end
  end

  // Payload needs no reset: it is only ever read through ent_vld.
  always_ff @(posedge clk) begin
    if (xfer) begin
      if (take_new[0]) begin
        ent_dist[0] <= bus.in_distance;
        ent_type[0] <= bus.in_type;
      end
      for (int i = 1; i < K; i++) begin
        if (take_new[i]) begin
          ent_dist[i] <= bus.in_distance;
          ent_type[i] <= bus.in_type;
        end else if (take_prev[i]) begin
          ent_dist[i] <= ent_dist[i-1];
          ent_type[i] <= ent_type[i-1];
        end
      end
    end
  end

  // Score of the class currently being scanned
  always_comb begin
    score = '0;
    for (int r = 0; r < K; r++) begin
      if (ent_vld[r] && ent_type[r] == cls) begin
`ifdef KNN_WEIGHTED_VOTE_EN
        score = score + SCORE_W'(K - r);
`else
        score = score + SCORE_W'(1);
`endif
      end
    end
  end

  // Vote scan. The running best starts at class 0 with score 0 and only a
  // strictly greater score replaces it, so ties keep the lower class. The
  // final decision is folded in on the last scan cycle so inferred_type is
  // already valid while inference_done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls        <= '0;
      best_score <= '0;
      best_type  <= '0;
      inferred_q <= '0;
    end else if (state == S_COLLECT) begin
      cls        <= '0;
      best_score <= '0;
      best_type  <= '0;
    end else if (state == S_VOTE) begin
      cls <= cls + 1'b1;
      if (score > best_score) begin
        best_score <= score;
        best_type  <= cls;
      end
      if (last_cls) inferred_q <= (score > best_score) ? cls : best_type;
    end
  end

endmodule
